// File: rtl/uncached_bridge.sv
// uncached_bridge: CPU sram-like uncached access to single-beat AXI, one outstanding, strict order.
// Optional UNCACHED_WBUF_EN: posted one-entry write buffer (store acked before B arrives).
module uncached_bridge #(
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            data_req,
   input  logic            data_wr,
   input  logic [1:0]      data_size,
   input  logic [31:0]     data_addr,
   input  logic [31:0]     data_wdata,
   output logic            data_addr_ok,
   output logic            data_data_ok,
   output logic [31:0]     data_rdata,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [31:0]     rdata,
   input  logic            rvalid,
   output logic            rready,
   input  logic            rlast,
   input  logic [1:0]      rresp,
   input  logic [ID_W-1:0] rid,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   output logic [ID_W-1:0] wid,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   input  logic            bvalid,
   output logic            bready,
   input  logic [ID_W-1:0] bid
);
   localparam logic [2:0] IDLE = 3'd0, RADDR = 3'd1, RDATA = 3'd2, WADDR = 3'd3, WRESP = 3'd4;
`ifdef UNCACHED_WBUF_EN
   localparam logic WBUF = 1'b1;
`else
   localparam logic WBUF = 1'b0;
`endif
   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  wstrb_q, wstrb_d, strb;
   logic        aw_done_q, aw_done_d, w_done_q, w_done_d, ok_q, ok_d;
   logic        unused_ok;
   assign unused_ok = ^{rlast, rresp, rid, bid};
   assign strb = data_size == 2'd0 ? 4'b0001 << data_addr[1:0] :
                 data_size == 2'd1 ? 4'b0011 << {data_addr[1], 1'b0} : 4'b1111;
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      ok_d      = 1'b0;
      case (state_q)
         IDLE: if (data_req) begin
            addr_d    = data_addr;
            size_d    = data_size;
            wdata_d   = data_wdata;
            wstrb_d   = strb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            ok_d      = WBUF & data_wr;
            state_d   = data_wr ? WADDR : RADDR;
         end
         RADDR: state_d = arready ? RDATA : RADDR;
         RDATA: if (rvalid) begin
            rdata_d = rdata;
            ok_d    = 1'b1;
            state_d = IDLE;
         end
         WADDR: begin
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
            state_d   = aw_done_d && w_done_d ? WRESP : WADDR;
         end
         WRESP: if (bvalid) begin
            ok_d    = ~WBUF;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         ok_q      <= ok_d;
      end
   end
   // A busy posted store keeps the FSM out of IDLE, so loads cannot overtake it.
   assign data_addr_ok = state_q == IDLE && data_req;
   assign data_data_ok = ok_q;
   assign data_rdata   = rdata_q;
   assign arid    = AXI_ID;
   assign araddr  = addr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = 2'b01;
   assign arvalid = state_q == RADDR;
   assign rready  = state_q == RDATA;
   assign awid    = AXI_ID;
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awvalid = state_q == WADDR && !aw_done_q;
   assign wid     = AXI_ID;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = state_q == WADDR && !w_done_q;
   assign bready  = state_q == WRESP;
endmodule

// File: tb/tb_uncached_bridge.sv
// tb_uncached_bridge: randomized loads/stores against a transaction-level model of the bridge.
module tb_uncached_bridge;
`ifdef UNCACHED_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif
   logic clk = 1'b0, resetn = 1'b0;
   logic data_req = 0, data_wr = 0;
   logic [1:0] data_size = 0;
   logic [31:0] data_addr = 0, data_wdata = 0;
   logic data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0] arid, awid, wid, rid = 0, bid = 0;
   logic [31:0] araddr, awaddr, wdata, rdata = 0;
   logic [7:0] arlen, awlen;
   logic [2:0] arsize, awsize;
   logic [1:0] arburst, awburst, rresp = 0;
   logic arvalid, arready = 0, rvalid = 0, rready, rlast = 0;
   logic awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
   logic [3:0] wstrb;
   int checks = 0, failures = 0, ok_cnt = 0;

   uncached_bridge dut (
      .clk(clk), .resetn(resetn), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .rlast(rlast), .rresp(rresp), .rid(rid),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready), .bid(bid)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (data_data_ok === 1'b1) ok_cnt++;

   function automatic logic [3:0] lanes(input logic [31:0] a, input logic [1:0] sz);
      int n, lo;
      logic [3:0] m;
      n  = sz == 0 ? 1 : sz == 1 ? 2 : 4;
      lo = (int'(a[1:0]) / n) * n;
      for (int i = 0; i < 4; i++) m[i] = (i >= lo) && (i < lo + n);
      return m;
   endfunction

   task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd,
                          input int ard, input int rdd);
      int base;
      base = ok_cnt;
      @(negedge clk); data_req = 1; data_wr = 0; data_addr = a; data_size = sz; #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL load_addr_ok got=%b exp=1", data_addr_ok); end
      @(negedge clk); data_req = 0;
      for (int c = 0; c <= ard; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if (arvalid !== 1'b1 || araddr !== a || arsize !== {1'b0, sz} || arlen !== 8'd0 || arburst !== 2'b01 || arid !== 4'd1) begin
            failures++;
            $display("FAIL ar_channel got v=%b a=%h s=%0d len=%0d b=%0d id=%0d exp v=1 a=%h s=%0d len=0 b=1 id=1",
                     arvalid, araddr, arsize, arlen, arburst, arid, a, sz);
         end
         arready = c == ard;
      end
      @(negedge clk); arready = 0;
      checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin failures++; $display("FAIL rdata_phase got arvalid=%b rready=%b exp 0/1", arvalid, rready); end
      for (int c = 0; c <= rdd; c++) begin
         if (c > 0) @(negedge clk);
         rvalid = c == rdd;
         rdata  = c == rdd ? rd : $urandom;
      end
      @(negedge clk); rvalid = 0;
      checks++;
      if (data_data_ok !== 1'b1 || data_rdata !== rd || rready !== 1'b0) begin
         failures++;
         $display("FAIL load_data got ok=%b rdata=%h rready=%b exp ok=1 rdata=%h rready=0", data_data_ok, data_rdata, rready, rd);
      end
      @(negedge clk);
      checks++; if (ok_cnt - base !== 1) begin failures++; $display("FAIL load_ok_pulses got=%0d exp=1", ok_cnt - base); end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input int awd, input int wdd, input int bd);
      int base, mx;
      logic [3:0] es;
      base = ok_cnt;
      es = lanes(a, sz);
      mx = awd > wdd ? awd : wdd;
      @(negedge clk); data_req = 1; data_wr = 1; data_addr = a; data_size = sz; data_wdata = wd; #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL store_addr_ok got=%b exp=1", data_addr_ok); end
      @(negedge clk); data_req = 0;
      checks++; if (data_data_ok !== WBUF) begin failures++; $display("FAIL store_early_ok got=%b exp=%b", data_data_ok, WBUF); end
      for (int c = 0; c <= mx; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if (awvalid !== (c <= awd) || wvalid !== (c <= wdd)) begin
            failures++;
            $display("FAIL aw_w_valid cyc=%0d got aw=%b w=%b exp aw=%b w=%b", c, awvalid, wvalid, c <= awd, c <= wdd);
         end
         if (awvalid === 1'b1) begin
            checks++;
            if (awaddr !== a || awsize !== {1'b0, sz} || awlen !== 8'd0 || awburst !== 2'b01 || awid !== 4'd1) begin
               failures++;
               $display("FAIL aw_channel got a=%h s=%0d len=%0d b=%0d id=%0d exp a=%h s=%0d", awaddr, awsize, awlen, awburst, awid, a, sz);
            end
         end
         if (wvalid === 1'b1) begin
            checks++;
            if (wdata !== wd || wstrb !== es || wlast !== 1'b1 || wid !== 4'd1) begin
               failures++;
               $display("FAIL w_channel got d=%h strb=%b last=%b id=%0d exp d=%h strb=%b last=1 id=1", wdata, wstrb, wlast, wid, wd, es);
            end
         end
         awready = c == awd;
         wready  = c == wdd;
      end
      @(negedge clk); awready = 0; wready = 0;
      checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
         failures++;
         $display("FAIL wresp_phase got aw=%b w=%b bready=%b exp 0/0/1", awvalid, wvalid, bready);
      end
      for (int c = 0; c <= bd; c++) begin
         if (c > 0) @(negedge clk);
         bvalid = c == bd;
      end
      @(negedge clk); bvalid = 0;
      checks++;
      if (data_data_ok !== !WBUF || bready !== 1'b0) begin
         failures++;
         $display("FAIL store_done got ok=%b bready=%b exp ok=%b bready=0", data_data_ok, bready, !WBUF);
      end
      @(negedge clk);
      checks++; if (ok_cnt - base !== 1) begin failures++; $display("FAIL store_ok_pulses got=%0d exp=1", ok_cnt - base); end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({arvalid, awvalid, wvalid, rready, bready, data_data_ok, data_addr_ok} !== 7'b0 ||
          araddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0 || data_rdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_state got v=%b a=%h wd=%h s=%b rd=%h exp all zero",
                  {arvalid, awvalid, wvalid, rready, bready, data_data_ok, data_addr_ok}, araddr, wdata, wstrb, data_rdata);
      end
   endtask

   task automatic test_directed;
      do_load(32'h1FAF_F000, 2'd2, 32'hDEAD_BEEF, 0, 2);
      do_store(32'h1FAF_F003, 2'd0, 32'hAB00_0000, 0, 0, 1);
      checks++; if (lanes(32'h1FAF_F003, 2'd0) !== 4'b1000) begin failures++; $display("FAIL byte_lane_model got=%b exp=1000", lanes(32'h1FAF_F003, 2'd0)); end
      do_store(32'h1FAF_F002, 2'd1, 32'h5A5A_0000, 3, 0, 0);
      do_store(32'h1FAF_F001, 2'd3, 32'h1234_5678, 1, 1, 0);
   endtask

   task automatic test_back_to_back;
      @(negedge clk); data_req = 1; data_wr = 0; data_addr = 32'h1FAF_F010; data_size = 2; #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL b2b_first_ok got=%b exp=1", data_addr_ok); end
      @(negedge clk); arready = 1; #1;
      checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL b2b_ok_in_raddr got=%b exp=0", data_addr_ok); end
      @(negedge clk); arready = 0; rvalid = 1; rdata = 32'hCAFE_0001; #1;
      checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL b2b_ok_in_rdata got=%b exp=0", data_addr_ok); end
      @(negedge clk); rvalid = 0; data_addr = 32'h1FAF_F020; #1;
      checks++;
      if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b1 || data_rdata !== 32'hCAFE_0001) begin
         failures++;
         $display("FAIL b2b_second_ok got data_ok=%b addr_ok=%b rd=%h exp 1/1/cafe0001", data_data_ok, data_addr_ok, data_rdata);
      end
      @(negedge clk); data_req = 0; arready = 1; #1;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h1FAF_F020) begin failures++; $display("FAIL b2b_second_ar got v=%b a=%h exp 1/1faff020", arvalid, araddr); end
      @(negedge clk); arready = 0; rvalid = 1; rdata = 32'hCAFE_0002;
      @(negedge clk); rvalid = 0;
      checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFE_0002) begin failures++; $display("FAIL b2b_second_data got ok=%b rd=%h exp 1/cafe0002", data_data_ok, data_rdata); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk); data_req = 1; data_wr = 0; data_addr = 32'h1FAF_F100; data_size = 2;
      @(negedge clk); data_req = 0; arready = 1;
      @(negedge clk); arready = 0; #1;
      checks++; if (rready !== 1'b1) begin failures++; $display("FAIL pre_reset_rready got=%b exp=1", rready); end
      #1 resetn = 0; #1;
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || data_data_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got ar=%b r=%b ok=%b aok=%b exp all 0", arvalid, rready, data_data_ok, data_addr_ok);
      end
      @(negedge clk); resetn = 1;
      @(negedge clk);
      checks++; if (rready !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got r=%b ar=%b exp 0/0", rready, arvalid); end
      do_load(32'h1FAF_F104, 2'd2, 32'h0BAD_F00D, 0, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, d;
         logic [1:0] sz;
         a  = $urandom;
         d  = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_store(a, sz, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_load(a, sz, d, $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

`ifdef UNCACHED_WBUF_EN
   task automatic test_wbuf;
      @(negedge clk); data_req = 1; data_wr = 1; data_addr = 32'h1FAF_F200; data_size = 2; data_wdata = 32'h7777_8888;
      @(negedge clk); data_wr = 0; data_addr = 32'h1FAF_F204; awready = 1; wready = 1; #1;
      checks++; if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL wbuf_early got ok=%b aok=%b exp 1/0", data_data_ok, data_addr_ok); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); awready = 0; wready = 0; #1;
         checks++; if (data_addr_ok !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL wbuf_hold got aok=%b ar=%b exp 0/0", data_addr_ok, arvalid); end
      end
      bvalid = 1; #1;
      checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL wbuf_hold_b got aok=%b exp 0", data_addr_ok); end
      @(negedge clk); bvalid = 0; #1;
      checks++; if (data_addr_ok !== 1'b1 || arvalid !== 1'b0 || data_data_ok !== 1'b0) begin failures++; $display("FAIL wbuf_release got aok=%b ar=%b ok=%b exp 1/0/0", data_addr_ok, arvalid, data_data_ok); end
      @(negedge clk); data_req = 0; arready = 1; #1;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h1FAF_F204) begin failures++; $display("FAIL wbuf_load_ar got v=%b a=%h exp 1/1faff204", arvalid, araddr); end
      @(negedge clk); arready = 0; rvalid = 1; rdata = 32'h4444_5555;
      @(negedge clk); rvalid = 0;
      checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h4444_5555) begin failures++; $display("FAIL wbuf_load_data got ok=%b rd=%h exp 1/44445555", data_data_ok, data_rdata); end
   endtask
`endif

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      @(negedge clk); resetn = 1;
      test_directed;
      test_back_to_back;
      test_reset_mid;
      test_random;
`ifdef UNCACHED_WBUF_EN
      test_wbuf;
`endif
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uncached_bridge.md
Name: uncached_bridge

Overview:
Converts the CPU's physically-addressed uncached data accesses (kseg1, flagged for dcache bypass) into single-beat AXI transactions and returns the result on the CPU sram-like handshake. Sits between the address-translation stage and the AXI interconnect, alongside the dcache. Handles one outstanding access at a time and keeps strict program order, as required for confreg and MMIO.

Parameters:
AXI_ID, 4'd1, ID driven on arid/awid/wid; rid/bid are not checked
ID_W, 4, width of the AXI ID fields

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
data_req  in  1  CPU uncached request valid
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  physical address
data_wdata  in  32  store data, lane-aligned
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  load data or store completion valid (1-cycle pulse)
data_rdata  out  32  load data, raw 32-bit bus word
arid/awid/wid  out  ID_W  = AXI_ID
araddr/awaddr  out  32  latched data_addr
arlen/awlen  out  8  always 0
arsize/awsize  out  3  {1'b0, latched size}
arburst/awburst  out  2  always 2'b01
arvalid/awvalid  out  1  address valid
arready/awready  in  1  address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
rlast, rresp, rid  in  1/2/ID_W  ignored
wdata  out  32  latched store data
wstrb  out  4  byte strobes
wlast  out  1  always 1
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP. Reset state is IDLE. On reset, every valid/ok output, bready and rready are 0, and all latches are 0.
- IDLE: data_addr_ok = data_req, combinational. On data_req, latch addr, size, wr and wdata, and compute wstrb. Go to RADDR if wr = 0, otherwise WADDR.
- wstrb encoding:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
  - size = 3 is illegal: treat as word.
- RADDR: arvalid = 1 and held until arready. On handshake go to RDATA.
- RDATA: rready = 1. On rvalid, register rdata into data_rdata, pulse data_data_ok the next cycle, and return to IDLE.
- WADDR: awvalid and wvalid are asserted together. Each one deasserts independently after its own handshake (tracked by aw_done and w_done flags). When both are done, go to WRESP. AW and W handshakes may occur in either order or in the same cycle.
- WRESP: bready = 1. On bvalid, pulse data_data_ok the next cycle and return to IDLE.
- Latency: addr_ok to data_ok is at least 3 cycles with zero-wait AXI.
- data_addr_ok is 0 in every state except IDLE. A new request is accepted no earlier than the cycle in which data_data_ok pulses, because the FSM is back in IDLE then.
- Address and data outputs hold stable while their valid is high, as required by AXI.
- Reset asserted mid-transaction: return immediately to IDLE with all valid signals dropped. The interconnect is reset together with the bridge.

Optional Feature:
UNCACHED_WBUF_EN
- Defined: one-entry posted write buffer.
  - A store in IDLE is acked with data_addr_ok, and data_data_ok pulses the next cycle without waiting for B.
  - The AW/W/B sequence then drains in the background.
  - While the buffer is busy, any new request (load or store) gets data_addr_ok = 0 until bvalid completes. This preserves ordering: a load can never pass a store.
- Undefined: stores complete only after B, as described above.

Test Plan:
- Word load, addr 0x1FAF_F000, arready = 1, and rvalid 2 cycles after the AR handshake with rdata = 0xDEAD_BEEF -> araddr = 0x1FAF_F000, arsize = 2, data_rdata = 0xDEAD_BEEF, exactly one data_data_ok pulse.
- Byte store, addr 0x1FAF_F003, wdata = 0xAB00_0000 -> wstrb = 4'b1000, awsize = 0, wlast = 1, data_data_ok one cycle after bvalid.
- Half store, addr 0x1FAF_F002, with wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid holds until its own handshake, and a single B is consumed.
- Back-to-back request held high after data_data_ok -> second addr_ok in the data_ok cycle, and addr_ok is never high outside IDLE.
- resetn pulled low during RDATA -> arvalid, rready and data_data_ok are 0 immediately, and the FSM is IDLE on release.
- With UNCACHED_WBUF_EN: a store followed immediately by a load -> store data_ok arrives before the B response, the load's addr_ok is held 0 until bvalid, and arvalid rises only after the B handshake.
